imm_gen_pipe: RTL and testbench

//  Registered, flow-controlled successor of the RV immediate/sign-extension unit.

---
 rtl/imm_gen_pipe.sv | 133 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | imm_gen_pipe: RV immediate extraction/extension behind a valid/ready skid |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     cod,
  input  logic [3:0]      ext_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic            imm_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]     imm32;
  logic            sign_ext;
  logic [63:0]     imm64;
  logic [XLEN-1:0] new_imm;
  logic            new_err;

  logic [XLEN-1:0] slot0_imm;
  logic            slot0_err;
  logic [XLEN-1:0] slot1_imm;
  logic            slot1_err;

  logic push;
  logic pop;

  // Every format is first formed at 32 bits, then widened uniformly to XLEN.
  always_comb begin
    imm32    = 32'd0;
    sign_ext = 1'b0;
    new_err  = 1'b0;
    case (ext_sel)
      4'd0: begin imm32 = {{20{cod[31]}}, cod[31:20]};                              sign_ext = 1'b1; end
      4'd1: begin imm32 = {{20{cod[31]}}, cod[31:25], cod[11:7]};                   sign_ext = 1'b1; end
      4'd2: begin imm32 = {{19{cod[31]}}, cod[31], cod[7], cod[30:25], cod[11:8], 1'b0}; sign_ext = 1'b1; end
      4'd3: begin imm32 = {cod[31:12], 12'b0};                                       sign_ext = 1'b1; end
      4'd4: begin imm32 = {{11{cod[31]}}, cod[31], cod[19:12], cod[20], cod[30:21], 1'b0}; sign_ext = 1'b1; end
      4'd5: imm32 = (XLEN == 64) ? {26'd0, cod[25:20]} : {27'd0, cod[24:20]};
      4'd6: imm32 = {27'd0, cod[19:15]};
      default: new_err = 1'b1;
    endcase
  end

  assign imm64   = {{32{sign_ext & imm32[31]}}, imm32};
  assign new_imm = imm64[XLEN-1:0];

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state != TWO);
    end else begin : g_single
      assign in_ready = (state == EMPTY) || out_ready;
    end
  endgenerate

  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign imm       = slot0_imm;
  assign imm_err   = slot0_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = (SKID != 0) ? TWO : ONE;
        else if (!push && pop) state_nxt = EMPTY;
      end
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // slot0 is always the head; slot1 only ever holds the word behind it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot0_imm <= '0;
      slot0_err <= 1'b0;
      slot1_imm <= '0;
      slot1_err <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            slot0_imm <= new_imm;
            slot0_err <= new_err;
          end
        end
        ONE: begin
          if (push && pop) begin
            slot0_imm <= new_imm;
            slot0_err <= new_err;
          end else if (push) begin
            slot1_imm <= new_imm;
            slot1_err <= new_err;
          end
        end
        TWO: begin
          if (pop) begin
            slot0_imm <= slot1_imm;
            slot0_err <= slot1_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_imm_gen_pipe: directed bench over XLEN=32/64 and SKID=1/0 instances    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_imm_gen_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // a: XLEN=32 SKID=1, b: XLEN=64 SKID=1, c: XLEN=32 SKID=0
  logic        a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0, a_err;
  logic [31:0] a_cod = '0;
  logic [3:0]  a_sel = '0;
  logic [31:0] a_imm;
  logic        b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0, b_err;
  logic [31:0] b_cod = '0;
  logic [3:0]  b_sel = '0;
  logic [63:0] b_imm;
  logic        c_iv = 1'b0, c_ir, c_ov, c_or = 1'b0, c_err;
  logic [31:0] c_cod = '0;
  logic [3:0]  c_sel = '0;
  logic [31:0] c_imm;

  imm_gen_pipe #(.XLEN(32), .SKID(1)) dut_a (
    .clock(clock), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .cod(a_cod),
    .ext_sel(a_sel), .out_valid(a_ov), .out_ready(a_or), .imm(a_imm), .imm_err(a_err));
  imm_gen_pipe #(.XLEN(64), .SKID(1)) dut_b (
    .clock(clock), .reset(reset), .in_valid(b_iv), .in_ready(b_ir), .cod(b_cod),
    .ext_sel(b_sel), .out_valid(b_ov), .out_ready(b_or), .imm(b_imm), .imm_err(b_err));
  imm_gen_pipe #(.XLEN(32), .SKID(0)) dut_c (
    .clock(clock), .reset(reset), .in_valid(c_iv), .in_ready(c_ir), .cod(c_cod),
    .ext_sel(c_sel), .out_valid(c_ov), .out_ready(c_or), .imm(c_imm), .imm_err(c_err));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [3:0] s, input logic [31:0] c);
    a_iv = v; a_sel = s; a_cod = c;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_a_ov", a_ov, 0);  chk("rst_a_imm", a_imm, 0); chk("rst_a_err", a_err, 0);
    chk("rst_b_ov", b_ov, 0);  chk("rst_b_imm", b_imm, 0);
    chk("rst_c_ov", c_ov, 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_a_ir", a_ir, 1); chk("rst_b_ir", b_ir, 1); chk("rst_c_ir", c_ir, 1);

    // single I-type word, latency 1
    @(negedge clock);
    a_or = 1'b1;
    drive_a(1, 4'd0, 32'hFFF00093);
    @(negedge clock);
    chk("t1_ov", a_ov, 1); chk("t1_imm", a_imm, 32'hFFFFFFFF); chk("t1_err", a_err, 0);
    drive_a(0, 4'd0, 32'h0);
    @(negedge clock);
    chk("t1_drain", a_ov, 0);

    // back-to-back words, one per cycle in order
    drive_a(1, 4'd3, 32'h12345037);
    @(negedge clock);
    chk("t2_u", a_imm, 32'h12345000); chk("t2_u_ov", a_ov, 1);
    drive_a(1, 4'd2, 32'hFE000EE3);
    @(negedge clock);
    chk("t2_b", a_imm, 32'hFFFFFFFC); chk("t2_b_ov", a_ov, 1);
    drive_a(1, 4'd0, 32'h47FFFFFF);
    @(negedge clock);
    chk("t2_i", a_imm, 32'h0000047F); chk("t2_i_ov", a_ov, 1);
    drive_a(1, 4'd1, 32'h00A00523);
    @(negedge clock);
    chk("t2_s", a_imm, 32'h0000000A);
    drive_a(1, 4'd4, 32'h8000006F);
    @(negedge clock);
    chk("t2_j", a_imm, 32'hFFF00000);
    drive_a(1, 4'd5, 32'h03F01013);
    @(negedge clock);
    chk("t2_shamt32", a_imm, 32'h0000001F);
    drive_a(1, 4'd6, 32'h000F8073);
    @(negedge clock);
    chk("t2_zimm", a_imm, 32'h0000001F); chk("t2_zimm_err", a_err, 0);
    drive_a(1, 4'd9, 32'hFFFFFFFF);
    @(negedge clock);
    chk("t2_bad_imm", a_imm, 0); chk("t2_bad_err", a_err, 1);
    drive_a(0, 4'd0, 32'h0);
    @(negedge clock);
    chk("t2_drain", a_ov, 0);

    // stall with skid buffer: two accepted, third refused, drain in order
    a_or = 1'b0;
    drive_a(1, 4'd0, 32'hFFF00093);
    @(negedge clock);
    chk("t3_ir_one", a_ir, 1);
    drive_a(1, 4'd3, 32'h12345037);
    @(negedge clock);
    chk("t3_ir_two", a_ir, 0); chk("t3_head", a_imm, 32'hFFFFFFFF);
    drive_a(1, 4'd6, 32'h000F8073);
    @(negedge clock);
    chk("t3_ir_hold", a_ir, 0); chk("t3_stable", a_imm, 32'hFFFFFFFF); chk("t3_ov", a_ov, 1);
    drive_a(0, 4'd0, 32'h0);
    a_or = 1'b1;
    @(negedge clock);
    chk("t3_second", a_imm, 32'h12345000); chk("t3_ir_back", a_ir, 1); chk("t3_ov2", a_ov, 1);
    @(negedge clock);
    chk("t3_empty", a_ov, 0); chk("t3_ir_end", a_ir, 1);

    // XLEN=64 formats
    b_or = 1'b1;
    b_iv = 1'b1; b_sel = 4'd0; b_cod = 32'hFFF00093;
    @(negedge clock);
    chk("t4_i64", b_imm, 64'hFFFFFFFFFFFFFFFF);
    b_sel = 4'd5; b_cod = 32'h03F01013;
    @(negedge clock);
    chk("t4_shamt64", b_imm, 64'h3F);
    b_sel = 4'd3; b_cod = 32'h80000037;
    @(negedge clock);
    chk("t4_u64", b_imm, 64'hFFFFFFFF80000000);
    b_sel = 4'd14; b_cod = 32'h12345678;
    @(negedge clock);
    chk("t4_bad_imm", b_imm, 0); chk("t4_bad_err", b_err, 1);
    b_iv = 1'b0;
    @(negedge clock);
    chk("t4_drain", b_ov, 0);

    // single-register mode: pop and push in the same cycle
    c_or = 1'b0;
    c_iv = 1'b1; c_sel = 4'd0; c_cod = 32'hFFF00093;
    @(negedge clock);
    chk("t5_ov", c_ov, 1); chk("t5_ir_blocked", c_ir, 0); chk("t5_imm", c_imm, 32'hFFFFFFFF);
    c_or = 1'b1; c_sel = 4'd3; c_cod = 32'h12345037;
    #1;
    chk("t5_ir_open", c_ir, 1);
    @(negedge clock);
    chk("t5_ov_kept", c_ov, 1); chk("t5_imm2", c_imm, 32'h12345000);
    c_iv = 1'b0;
    @(negedge clock);
    chk("t5_drain", c_ov, 0);

    // asynchronous reset while two words are buffered
    a_or = 1'b0;
    drive_a(1, 4'd0, 32'hFFF00093);
    @(negedge clock);
    drive_a(1, 4'd3, 32'h12345037);
    @(negedge clock);
    drive_a(0, 4'd0, 32'h0);
    chk("t6_full", a_ir, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_ov", a_ov, 0); chk("t6_async_imm", a_imm, 0); chk("t6_async_err", a_err, 0);
    @(negedge clock);
    reset = 1'b0;
    a_or = 1'b1;
    #1;
    chk("t6_ir", a_ir, 1);
    @(negedge clock);
    chk("t6_no_stale1", a_ov, 0);
    @(negedge clock);
    chk("t6_no_stale2", a_ov, 0); chk("t6_imm_zero", a_imm, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
